// File: rtl/sha256_w_stream_if.sv
// Handshake bundle between the block source, the W-schedule generator and the compression stage.
// valid/ready rule: a transfer happens on a rising edge where both are high; valid never waits on ready.
interface sha256_w_stream_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;
    logic [479:0] window;

    modport master (
        output in_valid, block_in, w_ready,
        input  in_ready, w_valid, w_out, w_idx, w_last, window
    );

    modport slave (
        input  in_valid, block_in, w_ready,
        output in_ready, w_valid, w_out, w_idx, w_last, window
    );
endinterface

// File: rtl/sha256_w_stream.sv
// SHA-256 message schedule generator: takes one 512-bit block and streams W[0..63]
// from a 16-word shift register, expanding W[t+16] as each word is consumed.
module sha256_w_stream (
    input  logic             CLK,
    input  logic             RST,
    sha256_w_stream_if.slave bus,
    output logic             fsm_state
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] r [16];
    logic [5:0]  t_q;
    logic        armed_q;
    logic        load;
    logic        xfer;
    logic [31:0] w_new;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // armed_q keeps in_ready low while reset is held and for no longer.
    assign load  = (state_q == IDLE) && armed_q && bus.in_valid;
    assign xfer  = (state_q == RUN) && bus.w_ready;
    assign w_new = ssig1(r[14]) + r[9] + ssig0(r[1]) + r[0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = RUN;
            RUN:     if (xfer && (t_q == 6'd63)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            armed_q <= 1'b0;
            t_q     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                r[i] <= 32'd0;
            end
        end else begin
            armed_q <= 1'b1;
            if (load) begin
                t_q <= 6'd0;
                for (int i = 0; i < 16; i++) begin
                    r[i] <= bus.block_in[511 - 32*i -: 32];
                end
            end else if (xfer) begin
                // t saturates at 63; the FSM leaves RUN on that same transfer.
                if (t_q != 6'd63) begin
                    t_q <= t_q + 6'd1;
                end
                for (int i = 0; i < 15; i++) begin
                    r[i] <= r[i+1];
                end
                r[15] <= w_new;
            end
        end
    end

    always_comb begin
        bus.in_ready = armed_q && (state_q == IDLE);
        bus.w_valid  = (state_q == RUN);
        bus.w_last   = (state_q == RUN) && (t_q == 6'd63);
        bus.w_out    = r[0];
        bus.w_idx    = t_q;
        fsm_state    = state_q;
        bus.window   = '0;
        for (int i = 0; i < 15; i++) begin
            bus.window[479 - 32*i -: 32] = r[i];
        end
    end
endmodule

// File: tb/tb_sha256_w_stream.sv
// Bench for sha256_w_stream: table of blocks with a reference schedule model and
// scoreboard, plus hand sequences for back-to-back, ignored in_valid and async reset.
module tb_sha256_w_stream;
  logic CLK;
  logic RST;
  logic fsm_state;

  sha256_w_stream_if bus ();

  sha256_w_stream dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accepts  = 0;
  int accept_cyc = 0;
  int last_xfer_cyc = 0;
  int ready_pct = 100;

  logic [37:0]  exp_q[$];
  logic [31:0]  model_w [64];
  logic [31:0]  got_w [64];
  logic [479:0] got_win0;

  logic         stall_q = 1'b0;
  logic [31:0]  snap_w;
  logic [5:0]   snap_idx;
  logic [479:0] snap_win;

  typedef struct {
    logic [511:0] blk;
    int           pct;
    logic         chk_abc;
    logic [31:0]  w16;
    logic [31:0]  w17;
    logic [31:0]  w18;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  task automatic build_model(input logic [511:0] b);
    for (int t = 0; t < 16; t++) model_w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      model_w[t] = (rotr(model_w[t-2], 17) ^ rotr(model_w[t-2], 19) ^ (model_w[t-2] >> 10))
                 + model_w[t-7]
                 + (rotr(model_w[t-15], 7) ^ rotr(model_w[t-15], 18) ^ (model_w[t-15] >> 3))
                 + model_w[t-16];
    end
  endtask

  // w_ready driver
  initial begin
    bus.w_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      bus.w_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
    end
  end

  always @(posedge CLK) cyc++;

  // scoreboard / monitor, sampled mid-cycle
  always @(negedge CLK) begin
    logic [37:0] e;
    if (!RST) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_w_valid", bus.w_valid, 1'b1);
        check("stall_w_out", bus.w_out, snap_w);
        check("stall_w_idx", bus.w_idx, snap_idx);
        check("stall_window", bus.window, snap_win);
      end
      stall_q = bus.w_valid && !bus.w_ready;
      snap_w = bus.w_out;
      snap_idx = bus.w_idx;
      snap_win = bus.window;
      if (bus.w_valid) check("in_ready_run", bus.in_ready, 1'b0);
      else             check("w_last_idle", bus.w_last, 1'b0);
      if (bus.w_valid && bus.w_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_w_idx", bus.w_idx, 6'h3f ^ bus.w_idx);
        end else begin
          e = exp_q.pop_front();
          check("w_out", bus.w_out, e[31:0]);
          check("w_idx", bus.w_idx, e[37:32]);
          check("w_last", bus.w_last, e[37:32] == 6'd63);
          check("window_head", bus.window[479:448], bus.w_out);
          for (int k = 1; k < 15; k++) begin
            if ((k - 1) < exp_q.size() && exp_q[k-1][37:32] == 6'(e[37:32] + 6'(k)))
              check("window_ahead", bus.window[479 - 32*k -: 32], exp_q[k-1][31:0]);
          end
          got_w[e[37:32]] = bus.w_out;
          if (e[37:32] == 6'd0) got_win0 = bus.window;
          if (e[37:32] == 6'd63) last_xfer_cyc = cyc;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        build_model(bus.block_in);
        for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), model_w[t]});
        accepts++;
        accept_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic send_block(input logic [511:0] b);
    int n = 0;
    @(posedge CLK); #1;
    while (!bus.in_ready && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check("in_ready_wait", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.block_in = b;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.w_valid) && n < 3000) begin
      @(posedge CLK); #1;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", bus.w_valid, 1'b0);
  endtask

  task automatic wait_idx(input logic [5:0] idx);
    int n = 0;
    while (!(bus.w_valid && bus.w_idx == idx) && n < 1000) begin
      @(posedge CLK); #1;
      n++;
    end
    check("wait_idx", bus.w_idx, idx);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  logic [511:0] abc_blk;
  logic [511:0] blk_a;
  logic [511:0] blk_b;

  initial begin
    int n;
    abc_blk = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    vecs[0] = '{abc_blk, 100, 1'b1, 32'h61626380, 32'h000F0000, 32'h7DA86405};
    vecs[1] = '{abc_blk, 45, 1'b1, 32'h61626380, 32'h000F0000, 32'h7DA86405};
    vecs[2] = '{rand_block(), 70, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{rand_block(), 30, 1'b0, 32'h0, 32'h0, 32'h0};

    bus.in_valid = 1'b0;
    bus.block_in = '0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #2;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_w_valid", bus.w_valid, 1'b0);
    check("rst_w_last", bus.w_last, 1'b0);
    check("rst_w_out", bus.w_out, 32'h0);
    check("rst_w_idx", bus.w_idx, 6'h0);
    check("rst_window", bus.window, 480'h0);
    check("rst_fsm", fsm_state, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_held_in_ready", bus.in_ready, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // table-driven blocks
    for (int v = 0; v < 4; v++) begin
      ready_pct = vecs[v].pct;
      send_block(vecs[v].blk);
      wait_drain();
      if (vecs[v].chk_abc) begin
        check("abc_w0", got_w[0], 32'h61626380);
        check("abc_w15", got_w[15], 32'h00000018);
        check("abc_w16", got_w[16], vecs[v].w16);
        check("abc_w17", got_w[17], vecs[v].w17);
        check("abc_w18", got_w[18], vecs[v].w18);
        check("abc_window_t0", got_win0, {32'h61626380, 448'h0});
      end
    end

    // w_ready in IDLE must not move anything
    ready_pct = 100;
    repeat (5) @(posedge CLK);
    #1;
    check("idle_ready_w_valid", bus.w_valid, 1'b0);
    check("idle_ready_w_idx", bus.w_idx, 6'd63);
    check("idle_ready_in_ready", bus.in_ready, 1'b1);

    // back-to-back with in_valid held high
    blk_a = rand_block();
    blk_b = rand_block();
    n = accepts;
    @(posedge CLK); #1;
    bus.in_valid = 1'b1;
    bus.block_in = blk_a;
    @(posedge CLK); #1;
    bus.block_in = blk_b;
    while (accepts < n + 2 && cyc < 60000) begin
      @(posedge CLK); #1;
    end
    bus.in_valid = 1'b0;
    check("b2b_accepts", accepts, n + 2);
    check("b2b_gap", accept_cyc - last_xfer_cyc, 1);
    wait_drain();

    // in_valid pulse with another block at t = 20 is ignored
    ready_pct = 100;
    n = accepts;
    send_block(abc_blk);
    wait_idx(6'd20);
    bus.in_valid = 1'b1;
    bus.block_in = rand_block();
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    wait_drain();
    check("pulse_accepts", accepts, n + 1);
    check("pulse_w18", got_w[18], 32'h7DA86405);

    // async reset at t = 30
    ready_pct = 60;
    send_block(abc_blk);
    wait_idx(6'd30);
    #1 RST = 1'b0;
    #1;
    check("arst_w_valid", bus.w_valid, 1'b0);
    check("arst_in_ready", bus.in_ready, 1'b0);
    check("arst_w_out", bus.w_out, 32'h0);
    check("arst_w_idx", bus.w_idx, 6'h0);
    check("arst_window", bus.window, 480'h0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    check("arst_rel_in_ready", bus.in_ready, 1'b1);
    check("arst_rel_w_valid", bus.w_valid, 1'b0);
    check("arst_rel_w_last", bus.w_last, 1'b0);
    check("arst_rel_w_idx", bus.w_idx, 6'h0);
    check("arst_rel_window", bus.window, 480'h0);
    ready_pct = 100;
    send_block(vecs[2].blk);
    wait_drain();
    check("arst_next_w0", got_w[0], vecs[2].blk[511:480]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
